// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge APB sequencer: FSM states, the queued
// request record and the slave-index decode.
package apb_bridge_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

    function automatic logic [1:0] slv_idx(input logic [ADDR_W-1:0] addr, input int dec_lo);
        return addr[dec_lo +: 2];
    endfunction

endpackage

// File: rtl/apb_req_buf.sv
// One-entry holding register for a request accepted while the APB bus is busy.
module apb_req_buf
    import apb_bridge_pkg::*;
(
    input  logic     HCLK,
    input  logic     HRESETn,
    input  logic     push,
    input  logic     pop,
    input  apb_req_t din,
    output logic     valid,
    output apb_req_t dout
);

    logic     valid_reg;
    apb_req_t data_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (push) begin
            valid_reg <= 1'b1;
            data_reg  <= din;
        end else if (pop) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign dout  = data_reg;

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB master sequencer: takes single requests over valid/ready, runs the
// SETUP/ACCESS handshake on one of NUM_SLV slaves and returns data/error.
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int DEC_LO  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_write,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    output logic               PWRITE,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PENABLE,
    input  logic [DATA_W-1:0]  PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         sel_idx_reg;
    logic [ADDR_W-1:0]  paddr_reg;
    logic [DATA_W-1:0]  pwdata_reg;
    logic               pwrite_reg;
    logic               rsp_valid_reg, rsp_err_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;

    logic     pend_valid, accept, src_avail, src_hit;
    logic     can_launch, launch, complete, timeout, sel_active;
    logic     buf_push, buf_pop;
    logic [1:0] src_idx;
    apb_req_t pend_req, in_req, src_req;

    assign req_ready = !pend_valid;
    assign accept    = req_valid && req_ready;
    assign in_req    = '{addr: req_addr, write: req_write, wdata: req_wdata};

    // A held request is always older than anything arriving now, so it launches first.
    assign src_req   = pend_valid ? pend_req : in_req;
    assign src_avail = pend_valid || accept;
    assign src_idx   = slv_idx(src_req.addr, DEC_LO);
    assign src_hit   = int'(src_idx) < NUM_SLV;

    assign timeout  = (TIMEOUT > 0) && (state_reg == ACCESS) && !PREADY && (cnt_reg == CNT_LAST);
    assign complete = (state_reg == ACCESS) && (PREADY || timeout);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        can_launch = 1'b0;
        case (state_reg)
            IDLE:   can_launch = 1'b1;
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (complete) begin
                    can_launch = 1'b1;
                    cnt_next   = '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DERR:   can_launch = 1'b1;
            default: state_next = IDLE;
        endcase
        launch = can_launch && src_avail;
        if (can_launch) begin
            state_next = !src_avail ? IDLE : (src_hit ? SETUP : DERR);
        end
    end

    // A fresh request is parked only if it could not go straight onto the bus.
    assign buf_push = accept && !(launch && !pend_valid);
    assign buf_pop  = launch && pend_valid;

    apb_req_buf u_req_buf (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (buf_push),
        .pop     (buf_pop),
        .din     (in_req),
        .valid   (pend_valid),
        .dout    (pend_req)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_idx_reg   <= '0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pwrite_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (launch && src_hit) begin
                sel_idx_reg <= src_idx;
                paddr_reg   <= src_req.addr;
                pwdata_reg  <= src_req.wdata;
                pwrite_reg  <= src_req.write;
            end
            rsp_valid_reg <= complete || (state_reg == DERR);
            rsp_err_reg   <= (state_reg == DERR) || timeout || (complete && PREADY && PSLVERR);
            rsp_rdata_reg <= (complete && PREADY && !pwrite_reg) ? PRDATA : '0;
        end
    end

    assign sel_active = (state_reg == SETUP) || (state_reg == ACCESS);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_psel
            assign PSEL[gi] = sel_active && (sel_idx_reg == 2'(gi));
        end
    endgenerate

    assign PENABLE   = (state_reg == ACCESS);
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign PWRITE    = pwrite_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Scoreboard bench for apb_bridge_ctrl: a behavioural APB slave plays back planned
// wait states, and every response is checked against a plain rule-based model.
module tb_apb_bridge_ctrl;

    localparam int TO = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PREADY, PSLVERR;
    logic [2:0]  PSEL;

    apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .DEC_LO(12), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          wait_n;
        logic        slverr;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    setup_cyc_q[$];
    int    checks = 0;
    int    failures = 0;

    // slave-side state, written only by the slave process
    plan_t cur;
    int    wcnt = 0;
    int    acc_len = 0;
    int    last_access_len = 0;
    logic [2:0] cur_psel = 3'b000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int addr_idx(input logic [31:0] a);
        logic [1:0] f;
        f = a[13:12];
        return int'(f);
    endfunction

    // Expected completion from the transfer rules alone.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        e.addr = p.addr;
        if (addr_idx(p.addr) >= 3 || p.wait_n >= TO) begin
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end else begin
            e.err   = p.slverr;
            e.rdata = p.write ? 32'h0 : p.rdata;
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int wait_n, input logic serr, input logic [31:0] rd, input logic track);
        plan_t p;
        int    b;
        p.addr = addr; p.write = wr; p.wdata = wd;
        p.wait_n = wait_n; p.slverr = serr; p.rdata = rd;
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
        b = 0;
        while (!req_ready && b < 200) begin
            @(negedge HCLK);
            b++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        if (track) begin
            exp_q.push_back(model(p));
            if (addr_idx(addr) < 3) plan_q.push_back(p);
        end
        @(posedge HCLK);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_rsp(input string name);
        int b = 0;
        @(negedge HCLK);
        while (!rsp_valid && b < 100) begin
            @(negedge HCLK);
            b++;
        end
        if (!rsp_valid) chk(name, 0, 1);
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge HCLK);
            b++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Behavioural APB slave: replays each planned transfer's wait states.
    initial begin
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                PREADY = 1'b0;
            end else if (PSEL != 3'b000 && !PENABLE) begin
                if (plan_q.size() == 0) begin
                    chk("setup_unplanned", {61'h0, PSEL}, 0);
                end else begin
                    cur = plan_q.pop_front();
                    cur_psel = 3'b001 << addr_idx(cur.addr);
                    chk("setup_psel", {61'h0, PSEL}, {61'h0, cur_psel});
                    chk("setup_paddr", {32'h0, PADDR}, {32'h0, cur.addr});
                    chk("setup_pwrite", {63'h0, PWRITE}, {63'h0, cur.write});
                    if (cur.write) chk("setup_pwdata", {32'h0, PWDATA}, {32'h0, cur.wdata});
                    wcnt = cur.wait_n;
                    PRDATA = cur.rdata;
                    PSLVERR = cur.slverr;
                end
                setup_cyc_q.push_back(cyc);
                acc_len = 0;
                PREADY = 1'b0;
            end else if (PENABLE) begin
                acc_len++;
                last_access_len = acc_len;
                chk("access_psel_hold", {61'h0, PSEL}, {61'h0, cur_psel});
                chk("access_paddr_hold", {32'h0, PADDR}, {32'h0, cur.addr});
                if (wcnt == 0) begin
                    PREADY = 1'b1;
                end else begin
                    PREADY = 1'b0;
                    wcnt--;
                end
            end else begin
                PREADY = 1'b0;
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESETn && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
                    chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                    $display("rsp addr=%08h err=%0b rdata=%08h", e.addr, rsp_err, rsp_rdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits[7];
        logic [31:0] a;
        waits = '{0, 1, 2, 3, 15, 16, 25};
        req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);

        chk("rst_psel", {61'h0, PSEL}, 0);
        chk("rst_penable", {63'h0, PENABLE}, 0);
        chk("rst_paddr", {32'h0, PADDR}, 0);
        chk("rst_pwdata", {32'h0, PWDATA}, 0);
        chk("rst_pwrite", {63'h0, PWRITE}, 0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 0);
        chk("rst_rsp_err", {63'h0, rsp_err}, 0);
        chk("rst_rsp_rdata", {32'h0, rsp_rdata}, 0);
        chk("rst_req_ready", {63'h0, req_ready}, 1);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // zero-wait write to slave 1: SETUP T+1, ACCESS T+2, response T+3
        send(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'hA5A5_0001, 1'b1);
        chk("w1_setup_psel", {61'h0, PSEL}, 3'b010);
        chk("w1_setup_penable", {63'h0, PENABLE}, 0);
        @(posedge HCLK); #1;
        chk("w1_access_penable", {63'h0, PENABLE}, 1);
        @(posedge HCLK); #1;
        chk("w1_rsp_valid", {63'h0, rsp_valid}, 1);
        @(posedge HCLK); #1;
        chk("w1_rsp_pulse", {63'h0, rsp_valid}, 0);
        chk("w1_idle_psel", {61'h0, PSEL}, 0);
        chk("w1_idle_paddr_kept", {32'h0, PADDR}, 32'h0000_1004);

        // read from slave 2 with three wait states
        send(32'h0000_2010, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b1);
        wait_rsp("r2_rsp");
        chk("r2_access_len", last_access_len, 4);

        // decode miss: no select, one DERR cycle, response next cycle
        send(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        chk("miss_psel", {61'h0, PSEL}, 0);
        chk("miss_penable", {63'h0, PENABLE}, 0);
        chk("miss_rsp_early", {63'h0, rsp_valid}, 0);
        @(posedge HCLK); #1;
        chk("miss_rsp_valid", {63'h0, rsp_valid}, 1);
        chk("miss_rsp_err", {63'h0, rsp_err}, 1);
        chk("miss_psel_after", {61'h0, PSEL}, 0);

        // slave never ready: forced error after exactly TO access cycles
        send(32'h0000_0020, 1'b0, 32'h0, 40, 1'b0, 32'hFFFF_0000, 1'b1);
        wait_rsp("to_rsp");
        chk("to_access_len", last_access_len, TO);
        chk("to_idle_psel", {61'h0, PSEL}, 0);
        chk("to_idle_penable", {63'h0, PENABLE}, 0);
        repeat (2) @(negedge HCLK);

        // three back-to-back requests: SETUPs two cycles apart
        setup_cyc_q.delete();
        send(32'h0000_0100, 1'b1, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b1);
        send(32'h0000_1200, 1'b0, 32'h0, 0, 1'b1, 32'h2222_2222, 1'b1);
        chk("b2b_ready_full", {63'h0, req_ready}, 0);
        send(32'h0000_2300, 1'b1, 32'h3333_3333, 0, 1'b0, 32'h0, 1'b1);
        wait_drain();
        chk("b2b_setups", setup_cyc_q.size(), 3);
        if (setup_cyc_q.size() == 3) begin
            chk("b2b_gap1", setup_cyc_q[1] - setup_cyc_q[0], 2);
            chk("b2b_gap2", setup_cyc_q[2] - setup_cyc_q[1], 2);
        end

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            a[13:12] = 2'($urandom_range(0, 3));
            send(a, 1'($urandom), $urandom, waits[$urandom_range(0, 6)],
                 1'($urandom), $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge HCLK);
        end
        wait_drain();

        // reset in the middle of an access with the pending slot full
        send(32'h0000_1008, 1'b1, 32'hCAFE_F00D, 50, 1'b0, 32'h0, 1'b1);
        send(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge HCLK);
        chk("rst_mid_ready_full", {63'h0, req_ready}, 0);
        chk("rst_mid_penable", {63'h0, PENABLE}, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", {61'h0, PSEL}, 0);
        chk("rst_mid_penable_drop", {63'h0, PENABLE}, 0);
        exp_q.delete();
        plan_q.delete();
        @(negedge HCLK);
        chk("rst_mid_no_rsp", {63'h0, rsp_valid}, 0);
        HRESETn = 1'b1;
        chk("rst_mid_ready_after", {63'h0, req_ready}, 1);
        repeat (6) @(negedge HCLK);
        chk("rst_mid_idle_psel", {61'h0, PSEL}, 0);

        send(32'h0000_2004, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_CAFE, 1'b1);
        wait_drain();
        chk("plan_consumed", plan_q.size(), 0);

        repeat (3) @(negedge HCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
